// File: rtl/sha256_job_ctrl.sv
// sha256_job_ctrl
//   Job master for simplified_sha256. Loads NUM_OF_WORDS message words from a
//   valid/ready host stream into shared memory, pulses hash_start, waits for
//   the hasher to go busy and then idle again, and reads the 8 digest words
//   back out as a valid/ready stream (h0 first, out_last on h7).
// Ports
//   clk, reset_n          clock, async active-low reset
//   in_valid/in_ready/in_data         host message word stream
//   out_valid/out_ready/out_data/out_last  digest word stream
//   job_done              1-cycle pulse when digest word 7 is accepted
//   err                   sticky hasher timeout flag (cleared by next job)
//   hash_start/hash_done  hasher handshake (hash_done is an idle level)
//   message_addr/output_addr  constant region bases handed to the hasher
//   mem_we/mem_addr/mem_write_data/mem_read_data  controller memory port
module sha256_job_ctrl #(
  parameter int          NUM_OF_WORDS   = 20,
  parameter logic [15:0] MSG_ADDR       = 16'h0000,
  parameter logic [15:0] OUT_ADDR       = 16'h0100,
  parameter int          BUSY_LIMIT     = 16,
  parameter int          TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic        job_done,
  output logic        err,
  output logic        hash_start,
  input  logic        hash_done,
  output logic [15:0] message_addr,
  output logic [15:0] output_addr,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);
  localparam int CW   = $clog2(NUM_OF_WORDS + 1);
  localparam int WMAX = (BUSY_LIMIT > TIMEOUT_CYCLES) ? BUSY_LIMIT : TIMEOUT_CYCLES;
  localparam int WW   = $clog2(WMAX + 1);

  typedef enum logic [2:0] {
    IDLE, LOAD, START, WAIT_BUSY, WAIT_DONE, RD_ADDR, RD_WAIT, PRESENT
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;   // message words accepted this job
  logic [WW-1:0] wcnt;  // cycles spent in the current WAIT state
  logic [2:0]    k;     // digest word index
  logic          hs;

  // Gated by reset_n so in_ready also reads 0 while reset is held.
  assign in_ready     = reset_n & ((state == IDLE) | (state == LOAD));
  assign hs           = in_valid & in_ready;
  assign message_addr = MSG_ADDR;
  assign output_addr  = OUT_ADDR;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      cnt            <= '0;
      wcnt           <= '0;
      k              <= '0;
      out_valid      <= 1'b0;
      out_data       <= '0;
      out_last       <= 1'b0;
      job_done       <= 1'b0;
      err            <= 1'b0;
      hash_start     <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_write_data <= '0;
    end else begin
      mem_we     <= 1'b0;
      hash_start <= 1'b0;
      job_done   <= 1'b0;
      case (state)
        IDLE, LOAD: begin
          if (hs) begin
            mem_we         <= 1'b1;
            mem_addr       <= MSG_ADDR + 16'(cnt);
            mem_write_data <= in_data;
            cnt            <= cnt + CW'(1);
            if (state == IDLE) err <= 1'b0;
            state <= (cnt == CW'(NUM_OF_WORDS - 1)) ? START : LOAD;
          end
        end
        START: begin
          hash_start <= 1'b1;
          cnt        <= '0;
          wcnt       <= '0;
          state      <= WAIT_BUSY;
        end
        // hash_done is already high before start, so first wait for it to
        // drop; a hasher that never reacts is flagged after BUSY_LIMIT.
        WAIT_BUSY: begin
          if (!hash_done) begin
            wcnt  <= '0;
            state <= WAIT_DONE;
          end else if (wcnt == WW'(BUSY_LIMIT - 1)) begin
            err   <= 1'b1;
            state <= IDLE;
          end else begin
            wcnt <= wcnt + WW'(1);
          end
        end
        WAIT_DONE: begin
          if (hash_done) begin
            k        <= '0;
            mem_addr <= OUT_ADDR;  // address is on the bus during RD_ADDR
            state    <= RD_ADDR;
          end else if (wcnt == WW'(TIMEOUT_CYCLES - 1)) begin
            err   <= 1'b1;
            state <= IDLE;
          end else begin
            wcnt <= wcnt + WW'(1);
          end
        end
        // Memory samples mem_addr at the end of RD_ADDR; data is valid in RD_WAIT.
        RD_ADDR: state <= RD_WAIT;
        RD_WAIT: begin
          out_data  <= mem_read_data;
          out_valid <= 1'b1;
          out_last  <= (k == 3'd7);
          state     <= PRESENT;
        end
        PRESENT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (k == 3'd7) begin
              out_last <= 1'b0;
              job_done <= 1'b1;
              state    <= IDLE;
            end else begin
              k        <= k + 3'd1;
              mem_addr <= OUT_ADDR + 16'(k) + 16'd1;
              state    <= RD_ADDR;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
